seq_bit_serializer: RTL and testbench
=====================================

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits; legal range is 2..32.
REQ-002 Parameter LSB_FIRST, default 0, selects bit order: 0 sends MSB first, 1 sends LSB first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 din  input  WIDTH  parallel word to serialise.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 din_ready  output  1  block accepts din this cycle.
REQ-008 x  output  1  serial bit stream for the downstream 1010 detector's x input.
REQ-009 x_valid  output  1  x carries a frame bit this cycle.
REQ-010 done  output  1  one-cycle pulse coincident with the final bit of a frame.

Function
REQ-011 A word SHALL be accepted on any rising edge where din_valid and din_ready are both 1.
REQ-012 The FSM SHALL have the states IDLE and SHIFT, plus PARITY when SEQ_SER_PARITY_EN is defined.
REQ-013 IDLE -> SHIFT on accept; SHIFT holds for WIDTH cycles, tracked by a bit counter running 0..WIDTH-1.
REQ-014 After the last SHIFT cycle the FSM SHALL go to SHIFT on an accept in that cycle, otherwise to IDLE.
REQ-015 x and x_valid SHALL be registered, and the first bit SHALL appear the cycle after the accept edge.
REQ-016 x_valid SHALL be 1 for exactly WIDTH consecutive cycles per frame and 0 otherwise; x SHALL be 0 whenever x_valid is 0.
REQ-017 din_ready SHALL be 1 in IDLE and in the final bit cycle of a frame, and 0 otherwise.
REQ-018 An accept in the final bit cycle SHALL start the next frame with no gap: x_valid stays high.
REQ-019 din SHALL be captured entirely at accept; later changes to din SHALL NOT affect the frame in flight.
REQ-020 done SHALL be 1 only in the cycle presenting the final frame bit.
REQ-021 din_valid deasserted in IDLE SHALL leave all outputs at their idle values: x=0, x_valid=0, done=0.

Reset
REQ-022 While rst is 0: state=IDLE, counter=0, shift register=0, x=0, x_valid=0, done=0, and din_ready SHALL be forced to 0.
REQ-023 din_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse; no remaining bits SHALL be emitted after release.

Configuration
REQ-025 Macro SEQ_SER_PARITY_EN defined: after the WIDTH data bits, one PARITY cycle SHALL emit the even-parity bit (XOR of din) with x_valid=1.
REQ-026 With SEQ_SER_PARITY_EN defined, done and the din_ready window SHALL move to the PARITY cycle, and frame length SHALL be WIDTH+1.
REQ-027 Macro SEQ_SER_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent, and frame length SHALL be WIDTH.

Structure
REQ-028 Shared package seq_pkg SHALL hold the serializer state enum (IDLE, SHIFT, PARITY) and the default width constant SEQ_WORD_W=8.
REQ-029 The block SHALL be a single module with no sub-module; the counter and parity logic are inline.

Verification
REQ-030 WIDTH=8, LSB_FIRST=0, din=8'hA5 with a single accept -> x=1,0,1,0,0,1,0,1 over 8 cycles, x_valid high for 8 cycles, done high on the 8th cycle only.
REQ-031 din_valid held high with 8'h0A then 8'h0A -> 16 contiguous x_valid cycles, x=0000101000001010, two done pulses, and the downstream detector sees 1010 twice.
REQ-032 LSB_FIRST=1, din=8'h01 -> x=1,0,0,0,0,0,0,0.
REQ-033 rst pulled to 0 during the 4th bit of 8'hFF -> x=0, x_valid=0, and done never asserts; after release the block is IDLE with din_ready=1.
REQ-034 SEQ_SER_PARITY_EN defined, din=8'hA5 then 8'h07 -> 9-bit frames with parity bits 0 and 1, and done on each 9th cycle.
REQ-035 din changed mid-frame while din_valid=0 -> the in-flight frame is unchanged and din_ready stays 0 until the final bit.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared serializer state encoding and default word width
package seq_pkg;

  localparam int SEQ_WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

endpackage

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - parallel word to registered serial bit stream
// SEQ_SER_PARITY_EN adds a trailing even-parity bit cycle to each frame.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WORD_W,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_PEN  = CNT_W'(WIDTH - 2);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             done_q, done_d;
`ifdef SEQ_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic accept;
  logic final_bit;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // The ready window opens on whichever cycle presents the last frame bit.
`ifdef SEQ_SER_PARITY_EN
  assign final_bit = (state_q == PARITY);
`else
  assign final_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif

  assign din_ready = rst && ((state_q == IDLE) || final_bit);
  assign accept    = din_valid && din_ready;
  assign x         = x_q;
  assign x_valid   = xv_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_SER_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      x_d     = head_bit(din);
      sr_d    = drop_head(din);
      xv_d    = 1'b1;
`ifdef SEQ_SER_PARITY_EN
      par_d   = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
`ifdef SEQ_SER_PARITY_EN
            state_d = PARITY;
            x_d     = par_q;
            xv_d    = 1'b1;
            done_d  = 1'b1;
`else
            state_d = IDLE;
`endif
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            x_d   = head_bit(sr_q);
            sr_d  = drop_head(sr_q);
            xv_d  = 1'b1;
`ifndef SEQ_SER_PARITY_EN
            done_d = (cnt_q == CNT_PEN);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
`ifdef SEQ_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb/tb_seq_bit_serializer.sv - randomized self-checking bench for seq_bit_serializer
module tb_seq_bit_serializer;

  localparam int W = seq_pkg::SEQ_WORD_W;
`ifdef SEQ_SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] din, din2;
  logic         din_valid, din_valid2;
  logic         din_ready, x, x_valid, done;
  logic         din_ready2, x2, x_valid2, done2;

  seq_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .done(done)
  );

  seq_bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .x(x2), .x_valid(x_valid2), .done(done2)
  );

  int checks = 0;
  int errors = 0;

  // Pending frame bits as {last, bit}; head is what the DUT should show now.
  logic [1:0] mq[$];
  bit         last_acc;

  task automatic push_frame(input logic [W-1:0] w);
    for (int k = 0; k < W; k++) begin
      logic b;
      b = w[W-1-k];
`ifdef SEQ_SER_PARITY_EN
      mq.push_back({1'b0, b});
`else
      mq.push_back({(k == W - 1) ? 1'b1 : 1'b0, b});
`endif
    end
`ifdef SEQ_SER_PARITY_EN
    mq.push_back({1'b1, ^w});
`endif
  endtask

  function automatic logic [3:0] model_out();
    if (mq.size() == 0) return 4'b0001;
    return {mq[0][0], 1'b1, mq[0][1], (mq.size() == 1) ? 1'b1 : 1'b0};
  endfunction

  task automatic drive_edge(input logic v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    last_acc = v && (mq.size() <= 1);
    if (mq.size() > 0) void'(mq.pop_front());
    if (last_acc) push_frame(d);
  endtask

  task automatic test_reset();
    din_valid = 1'b1; din = 8'hFF; din_valid2 = 1'b1; din2 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, din_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b want 0000", i, {x, x_valid, done, din_ready});
      end
    end
    din_valid = 1'b0; din_valid2 = 1'b0;
    rst = 1'b1;
    mq.delete();
    @(negedge clk);
    checks++;
    if ({x, x_valid, done, din_ready, din_ready2} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_release got %b want 00011", {x, x_valid, done, din_ready, din_ready2});
    end
    drive_edge(1'b0, '0);
  endtask

  task automatic test_a5();
    logic [FL-1:0] seen;
    int nv, nd, done_at;
    seen = '0; nv = 0; nd = 0; done_at = -1;
    for (int i = 0; i < FL + 4; i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, din_ready} !== model_out()) begin
        errors++;
        $display("FAIL a5_cycle %0d got %b want %b", i, {x, x_valid, done, din_ready}, model_out());
      end
      if (x_valid) begin
        seen = {seen[FL-2:0], x};
        if (done) done_at = nv;
        nv++;
      end
      if (done) nd++;
      drive_edge(i == 0, (i == 0) ? 8'hA5 : 8'h00);
    end
    checks++;
    if (seen[FL-1 -: W] !== 8'hA5 || nv != FL || nd != 1 || done_at != FL - 1) begin
      errors++;
      $display("FAIL a5_frame bits %h valid %0d done %0d at %0d want a5 %0d 1 at %0d",
               seen[FL-1 -: W], nv, nd, done_at, FL, FL - 1);
    end
  endtask

  task automatic test_back_to_back();
    int nacc, nv, nd, hits, run, maxrun;
    logic [3:0] hist;
    nacc = 0; nv = 0; nd = 0; hits = 0; hist = '0; run = 0; maxrun = 0;
    for (int i = 0; i < 2 * FL + 4; i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, din_ready} !== model_out()) begin
        errors++;
        $display("FAIL b2b_cycle %0d got %b want %b", i, {x, x_valid, done, din_ready}, model_out());
      end
      if (x_valid) begin
        nv++; run++;
        hist = {hist[2:0], x};
        if (hist == 4'b1010) hits++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
      if (done) nd++;
      drive_edge(nacc < 2, 8'h0A);
      if (last_acc) nacc++;
    end
    checks++;
    if (nv != 2 * FL || maxrun != 2 * FL || nd != 2 || hits != 2) begin
      errors++;
      $display("FAIL b2b_summary valid %0d run %0d done %0d det %0d want %0d %0d 2 2",
               nv, maxrun, nd, hits, 2 * FL, 2 * FL);
    end
  endtask

  task automatic test_din_change();
    for (int i = 0; i < FL + 3; i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, din_ready} !== model_out()) begin
        errors++;
        $display("FAIL din_change cyc %0d got %b want %b", i, {x, x_valid, done, din_ready}, model_out());
      end
      drive_edge(i == 0, (i == 0) ? 8'h3C : W'($urandom));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400 + FL + 2; i++) begin
      logic v;
      v = (i < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, din_ready} !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", i, {x, x_valid, done, din_ready}, model_out());
      end
      drive_edge(v, W'($urandom));
    end
  endtask

  task automatic test_mid_reset();
    int nd;
    nd = 0;
    drive_edge(1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({x, x_valid, done, din_ready} !== model_out()) begin
        errors++;
        $display("FAIL midrst_pre bit %0d got %b want %b", i, {x, x_valid, done, din_ready}, model_out());
      end
      drive_edge(1'b0, '0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    mq.delete();
    checks++;
    if ({x, x_valid, done, din_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_abort got %b want 0000", {x, x_valid, done, din_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 1'b1;
    for (int i = 0; i < FL + 2; i++) begin
      @(negedge clk);
      if (done) nd++;
      checks++;
      if ({x, x_valid, done, din_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL midrst_after cyc %0d got %b want 0001", i, {x, x_valid, done, din_ready});
      end
      drive_edge(1'b0, '0);
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL midrst_done got %0d want 0", nd);
    end
  endtask

  task automatic test_lsb();
    logic [W-1:0] w;
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 8'h01 : W'($urandom);
      @(negedge clk);
      din2 = w; din_valid2 = 1'b1;
      @(posedge clk);
      for (int k = 0; k < FL; k++) begin
        logic eb;
        @(negedge clk);
        din_valid2 = 1'b0;
        din2 = W'($urandom);
        eb = (k < W) ? w[k] : ^w;
        checks++;
        if ({x2, x_valid2, done2} !== {eb, 1'b1, (k == FL - 1) ? 1'b1 : 1'b0}) begin
          errors++;
          $display("FAIL lsb word %h bit %0d got %b want %b", w, k, {x2, x_valid2, done2},
                   {eb, 1'b1, (k == FL - 1) ? 1'b1 : 1'b0});
        end
      end
      @(negedge clk);
      checks++;
      if ({x2, x_valid2, done2, din_ready2} !== 4'b0001) begin
        errors++;
        $display("FAIL lsb_idle word %h got %b want 0001", w, {x2, x_valid2, done2, din_ready2});
      end
    end
  endtask

  initial begin
    din = '0; din_valid = 1'b0; din2 = '0; din_valid2 = 1'b0;
    test_reset();
    test_a5();
    test_back_to_back();
    test_din_change();
    test_random();
    test_mid_reset();
    test_lsb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
